// File: rtl/mdio_pkg.sv
// Shared types and constants for the Clause-22 MDIO management master.
package mdio_pkg;

   typedef enum logic [2:0] {
      IDLE,
      PRE,
      HDR,
      TA,
      DATA,
      END
   } state_t;

   localparam logic [1:0] ADDR_CMD    = 2'd0;
   localparam logic [1:0] ADDR_WDATA  = 2'd1;
   localparam logic [1:0] ADDR_RDATA  = 2'd2;
   localparam logic [1:0] ADDR_STATUS = 2'd3;

   localparam logic [1:0] OP_READ  = 2'b10;
   localparam logic [1:0] OP_WRITE = 2'b01;
   localparam logic [1:0] ST       = 2'b01;

   localparam int unsigned PRE_LEN  = 32;
   localparam int unsigned HDR_LEN  = 14;
   localparam int unsigned TA_LEN   = 2;
   localparam int unsigned DATA_LEN = 16;

endpackage

// File: rtl/mdio_mdc_gen.sv
// MDC divider: low for the first half of each bit period, high for the second half.
// bit_end marks the last cycle of a period, so state registered there is visible from the next period's first cycle.
module mdio_mdc_gen #(
   parameter int unsigned CLK_DIV = 20
) (
   input  logic clk,
   input  logic reset_n,
   input  logic en,
   output logic mdc,
   output logic sample_en,
   output logic bit_end
);

   localparam int unsigned CW = $clog2(CLK_DIV);
   localparam logic [CW-1:0] HALF_LAST = CW'(CLK_DIV / 2 - 1);
   localparam logic [CW-1:0] LAST      = CW'(CLK_DIV - 1);

   logic [CW-1:0] cnt;

   always_ff @(posedge clk) begin
      if (!reset_n || !en) begin
         cnt <= '0;
         mdc <= 1'b0;
      end else begin
         cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
         if (cnt == HALF_LAST)
            mdc <= 1'b1;
         else if (cnt == LAST)
            mdc <= 1'b0;
      end
   end

   assign sample_en = en && (cnt == HALF_LAST);
   assign bit_end   = en && (cnt == LAST);

endmodule

// File: rtl/mdio_master.sv
// Clause-22 MDIO master with an Avalon-MM register slave; serialises one 64-bit frame per command.
module mdio_master
   import mdio_pkg::*;
#(
   parameter int unsigned CLK_DIV = 20
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [1:0]  address,
   input  logic        chipselect,
   input  logic        write_n,
   input  logic [31:0] writedata,
   output logic [31:0] readdata,
   output logic        mdc,
   output logic        mdio_o,
   output logic        mdio_oe,
   input  logic        mdio_i
);

   state_t      state;
   logic [4:0]  bit_cnt;
   logic [4:0]  cmd_reg;
   logic [4:0]  cmd_phy;
   logic        cmd_op;
   logic [15:0] wdata;
   logic [15:0] rdata;
   logic [15:0] shreg;
   logic        done;
   logic        busy;
   logic        wr;
   logic        sample_en;
   logic        bit_end;
   logic [13:0] hdr;
   logic [3:0]  hdr_idx;
   logic        unused_writedata;

   assign wr               = chipselect && !write_n;
   assign busy             = (state != IDLE);
   assign hdr              = {ST, (cmd_op ? OP_READ : OP_WRITE), cmd_phy, cmd_reg};
   assign hdr_idx          = 4'(HDR_LEN - 2) - bit_cnt[3:0];
   assign unused_writedata = ^writedata[31:16];

   mdio_mdc_gen #(.CLK_DIV(CLK_DIV)) u_mdc_gen (
      .clk       (clk),
      .reset_n   (reset_n),
      .en        (busy),
      .mdc       (mdc),
      .sample_en (sample_en),
      .bit_end   (bit_end)
   );

   // Outputs for bit n+1 are registered on the last cycle of bit n.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state   <= IDLE;
         bit_cnt <= '0;
         cmd_reg <= '0;
         cmd_phy <= '0;
         cmd_op  <= 1'b0;
         wdata   <= '0;
         rdata   <= '0;
         shreg   <= '0;
         done    <= 1'b0;
         mdio_o  <= 1'b1;
         mdio_oe <= 1'b0;
      end else begin
         if (wr && address == ADDR_WDATA)
            wdata <= writedata[15:0];
         if (wr && address == ADDR_STATUS && writedata[1])
            done <= 1'b0;
         if (sample_en && state == DATA && cmd_op)
            shreg <= {shreg[14:0], mdio_i};

         case (state)
            IDLE: begin
               if (wr && address == ADDR_CMD) begin
                  cmd_reg <= writedata[4:0];
                  cmd_phy <= writedata[9:5];
                  cmd_op  <= writedata[10];
                  shreg   <= wdata;
                  done    <= 1'b0;
                  state   <= PRE;
                  bit_cnt <= '0;
                  mdio_oe <= 1'b1;
                  mdio_o  <= 1'b1;
               end
            end
            PRE: begin
               if (bit_end) begin
                  if (bit_cnt == 5'(PRE_LEN - 1)) begin
                     state   <= HDR;
                     bit_cnt <= '0;
                     mdio_o  <= hdr[13];
                  end else begin
                     bit_cnt <= bit_cnt + 1'b1;
                  end
               end
            end
            HDR: begin
               if (bit_end) begin
                  if (bit_cnt == 5'(HDR_LEN - 1)) begin
                     state   <= TA;
                     bit_cnt <= '0;
                     mdio_oe <= !cmd_op;
                     mdio_o  <= 1'b1;
                  end else begin
                     bit_cnt <= bit_cnt + 1'b1;
                     mdio_o  <= hdr[hdr_idx];
                  end
               end
            end
            TA: begin
               if (bit_end) begin
                  if (bit_cnt == 5'(TA_LEN - 1)) begin
                     state   <= DATA;
                     bit_cnt <= '0;
                     mdio_o  <= cmd_op ? 1'b1 : shreg[15];
                  end else begin
                     bit_cnt <= bit_cnt + 1'b1;
                     mdio_o  <= cmd_op;
                  end
               end
            end
            DATA: begin
               if (bit_end) begin
                  if (!cmd_op)
                     shreg <= {shreg[14:0], 1'b0};
                  if (bit_cnt == 5'(DATA_LEN - 1)) begin
                     state   <= END;
                     bit_cnt <= '0;
                     mdio_oe <= 1'b0;
                     mdio_o  <= 1'b1;
                  end else begin
                     bit_cnt <= bit_cnt + 1'b1;
                     if (!cmd_op)
                        mdio_o <= shreg[14];
                  end
               end
            end
            END: begin
               if (bit_end) begin
                  state   <= IDLE;
                  bit_cnt <= '0;
                  done    <= 1'b1;
                  mdio_oe <= 1'b0;
                  mdio_o  <= 1'b1;
                  if (cmd_op)
                     rdata <= shreg;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         readdata <= '0;
      end else begin
         case (address)
            ADDR_CMD:   readdata <= {21'b0, cmd_op, cmd_phy, cmd_reg};
            ADDR_WDATA: readdata <= {16'b0, wdata};
            ADDR_RDATA: readdata <= {16'b0, rdata};
            default:    readdata <= {30'b0, done, busy};
         endcase
      end
   end

endmodule

// File: tb/tb_mdio_master.sv
// Bench for mdio_master: CLK_DIV 20 and CLK_DIV 4 builds, decoded on mdc rising edges against a frame model.
module tb_mdio_master;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [1:0]  address    [2];
   logic        chipselect [2];
   logic        write_n    [2];
   logic [31:0] writedata  [2];
   logic [31:0] readdata   [2];
   logic        mdc        [2];
   logic        mdio_o     [2];
   logic        mdio_oe    [2];
   logic        mdio_i     [2];

   logic [15:0] exp_rdata  [2];
   int n_pass  = 0;
   int n_fail  = 0;
   int n_total = 0;

   always #5 clk = ~clk;

   mdio_master #(.CLK_DIV(20)) dut0 (
      .clk(clk), .reset_n(reset_n), .address(address[0]), .chipselect(chipselect[0]),
      .write_n(write_n[0]), .writedata(writedata[0]), .readdata(readdata[0]),
      .mdc(mdc[0]), .mdio_o(mdio_o[0]), .mdio_oe(mdio_oe[0]), .mdio_i(mdio_i[0])
   );

   mdio_master #(.CLK_DIV(4)) dut1 (
      .clk(clk), .reset_n(reset_n), .address(address[1]), .chipselect(chipselect[1]),
      .write_n(write_n[1]), .writedata(writedata[1]), .readdata(readdata[1]),
      .mdc(mdc[1]), .mdio_o(mdio_o[1]), .mdio_oe(mdio_oe[1]), .mdio_i(mdio_i[1])
   );

   function automatic int div_of(input int d);
      return (d == 0) ? 20 : 4;
   endfunction

   // Expected line state at mdc rise k: 0/1 driven, 2 released.
   function automatic logic [1:0] exp_code(input int k, input logic [10:0] cmd, input logic [15:0] wd);
      logic [13:0] hdr;
      hdr = {2'b01, (cmd[10] ? 2'b10 : 2'b01), cmd[9:5], cmd[4:0]};
      if (k < 32) return 2'd1;
      if (k < 46) return {1'b0, hdr[45 - k]};
      if (cmd[10] || k >= 64) return 2'd2;
      if (k == 46) return 2'd1;
      if (k == 47) return 2'd0;
      return {1'b0, wd[63 - k]};
   endfunction

   function automatic logic phy_bit(input int k, input logic [15:0] phy);
      if (k == 47) return 1'b0;
      if (k >= 48 && k < 64) return phy[63 - k];
      return 1'b1;
   endfunction

   task automatic check(input string tag, input string what, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) begin
         n_pass++;
      end else begin
         n_fail++;
         $error("FAIL %s/%s: got 0x%0h, expected 0x%0h", tag, what, obs, exp);
      end
   endtask

   task automatic bus_idle(input int d);
      chipselect[d] = 1'b0;
      write_n[d]    = 1'b1;
      address[d]    = 2'd3;
   endtask

   task automatic bus_write(input int d, input logic [1:0] a, input logic [31:0] v);
      @(negedge clk);
      address[d] = a; writedata[d] = v; chipselect[d] = 1'b1; write_n[d] = 1'b0;
      @(negedge clk);
      bus_idle(d);
   endtask

   task automatic bus_read(input int d, input logic [1:0] a, output logic [31:0] v);
      @(negedge clk);
      address[d] = a; chipselect[d] = 1'b1; write_n[d] = 1'b1;
      @(negedge clk);
      v = readdata[d];
      bus_idle(d);
   endtask

   task automatic run_frame(input int d, input logic [10:0] cmd, input logic [15:0] wd,
                            input logic [15:0] phy, input int mid_at, input int clr_at,
                            input int abort_at, input string tag);
      int div, c, rises, hi_run, lo_run, bidx, dur;
      int bad_bits, bad_edge, bad_duty, bad_oe;
      logic prev_mdc, prev_oe, prev_o, stat_addr;
      logic [1:0] code;
      logic [31:0] v;
      div = div_of(d);
      rises = 0; hi_run = 0; lo_run = 0; dur = -1;
      bad_bits = 0; bad_edge = 0; bad_duty = 0; bad_oe = 0;
      prev_mdc = 1'b0; prev_oe = 1'b0; prev_o = 1'b1; stat_addr = 1'b0;
      mdio_i[d] = 1'b1;
      bus_write(d, 2'd1, {16'h0, wd});
      @(negedge clk);
      address[d] = 2'd0; writedata[d] = {21'b0, cmd}; chipselect[d] = 1'b1; write_n[d] = 1'b0;
      @(negedge clk);
      bus_idle(d);
      for (c = 0; c < 70 * div && dur < 0; c++) begin
         if (c > 0) @(negedge clk);
         if (c == abort_at) begin
            reset_n = 1'b0;
            @(negedge clk);
            check(tag, "rst_mdc", {31'b0, mdc[d]}, 32'd0);
            check(tag, "rst_oe", {31'b0, mdio_oe[d]}, 32'd0);
            check(tag, "rst_o", {31'b0, mdio_o[d]}, 32'd1);
            check(tag, "rst_readdata", readdata[d], 32'd0);
            reset_n = 1'b1;
            mdio_i[d] = 1'b1;
            exp_rdata[0] = '0;
            exp_rdata[1] = '0;
            bus_read(d, 2'd3, v);
            check(tag, "rst_status", v, 32'd0);
            return;
         end
         if (stat_addr && c >= 2 && readdata[d][0] === 1'b0) dur = c - 1;
         bidx = mdc[d] ? rises - 1 : rises;
         if (mdc[d] && !prev_mdc) begin
            code = mdio_oe[d] ? {1'b0, mdio_o[d]} : 2'd2;
            if (rises >= 65 || code !== exp_code(rises, cmd, wd)) bad_bits++;
            rises++;
            if (lo_run != div / 2) bad_duty++;
            lo_run = 0;
         end
         if (!mdc[d] && prev_mdc) begin
            if (hi_run != div / 2) bad_duty++;
            hi_run = 0;
            mdio_i[d] = phy_bit(rises, phy);
         end
         if (mdc[d]) hi_run++; else lo_run++;
         if (c > 0 && {mdio_oe[d], mdio_o[d]} !== {prev_oe, prev_o} && !(prev_mdc && !mdc[d]))
            bad_edge++;
         if (cmd[10] && bidx >= 46 && mdio_oe[d]) bad_oe++;
         prev_mdc = mdc[d]; prev_oe = mdio_oe[d]; prev_o = mdio_o[d];
         if (c == mid_at) begin
            address[d] = 2'd0; writedata[d] = {21'b0, cmd ^ 11'h7FF};
            chipselect[d] = 1'b1; write_n[d] = 1'b0;
         end else if (c == clr_at) begin
            address[d] = 2'd3; writedata[d] = 32'h2;
            chipselect[d] = 1'b1; write_n[d] = 1'b0;
         end else begin
            bus_idle(d);
         end
         stat_addr = (address[d] == 2'd3);
      end
      bus_idle(d);
      check(tag, "duration", dur, 65 * div);
      check(tag, "mdc_rises", rises, 32'd65);
      check(tag, "bad_bits", bad_bits, 32'd0);
      check(tag, "bad_edges", bad_edge, 32'd0);
      check(tag, "bad_duty", bad_duty, 32'd0);
      if (cmd[10]) begin
         check(tag, "oe_after_ta", bad_oe, 32'd0);
         exp_rdata[d] = phy;
      end
      bus_read(d, 2'd3, v);
      check(tag, "status", v, 32'h2);
      bus_read(d, 2'd2, v);
      check(tag, "rdata", v, {16'h0, exp_rdata[d]});
      bus_read(d, 2'd0, v);
      check(tag, "cmd_readback", v, {21'b0, cmd});
   endtask

   initial begin
      logic [31:0] v;
      logic [10:0] rc;
      reset_n = 1'b0;
      for (int d = 0; d < 2; d++) begin
         bus_idle(d);
         address[d] = 2'd0;
         writedata[d] = '0;
         mdio_i[d] = 1'b1;
         exp_rdata[d] = '0;
      end
      repeat (3) @(negedge clk);
      for (int d = 0; d < 2; d++) begin
         check("reset", "mdc", {31'b0, mdc[d]}, 32'd0);
         check("reset", "oe", {31'b0, mdio_oe[d]}, 32'd0);
         check("reset", "o", {31'b0, mdio_o[d]}, 32'd1);
         check("reset", "readdata", readdata[d], 32'd0);
      end
      reset_n = 1'b1;
      for (int a = 0; a < 4; a++) begin
         bus_read(0, 2'(a), v);
         check("reset", "reg", v, 32'd0);
      end

      run_frame(0, 11'h041, 16'h1234, 16'h0000, -1, -1, -1, "wr20");
      bus_write(0, 2'd3, 32'h2);
      bus_read(0, 2'd3, v);
      check("done_clear", "status", v, 32'd0);

      run_frame(0, 11'h4C3, 16'h1234, 16'hBEEF, -1, -1, -1, "rd20");
      run_frame(0, 11'h0A5, 16'hA5C3, 16'h0000, 100, -1, -1, "mid_cmd");
      run_frame(0, 11'h4E7, 16'h0F0F, 16'h3C5A, -1, 65 * 20 - 1, -1, "clr_at_end");
      run_frame(0, 11'h12D, 16'h8001, 16'h0000, 65 * 20 - 1, -1, -1, "cmd_at_end");
      run_frame(0, 11'h4C3, 16'h0000, 16'h7E81, -1, -1, 55 * 20 + 3, "abort");
      run_frame(0, 11'h4C3, 16'h0000, 16'h5AA5, -1, -1, -1, "post_rst");

      for (int i = 0; i < 3; i++) begin
         rc = 11'($urandom);
         run_frame(0, rc, 16'($urandom), 16'($urandom), -1, -1, -1, "rand20");
      end

      run_frame(1, 11'h041, 16'h1234, 16'h0000, -1, -1, -1, "wr4");
      run_frame(1, 11'h4C3, 16'h0000, 16'hBEEF, -1, -1, -1, "rd4");
      for (int i = 0; i < 2; i++) begin
         rc = 11'($urandom);
         run_frame(1, rc, 16'($urandom), 16'($urandom), -1, -1, -1, "rand4");
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
